fsram_bank_sched: RTL and testbench

- Ping-pong scheduler for the two feature SRAM banks (fsram1, fsram2).
- Grants write ownership of a bank to one of two writers: DRAM loader (id 0) or CCM write-back (id 1).
- Grants read ownership of a filled bank to the Data_process reader.
- Drives the reader bank-select lines, so tiles are consumed in the same order they were filled.

---
 rtl/fsram_bank_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_fsram_bank_sched.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fsram_bank_sched.sv
// rtl/fsram_bank_sched.sv - ping-pong write/read ownership scheduler for the two feature SRAM banks
// Optional stall counters: define FSRAM_SCHED_STALL_CNT_EN.
module fsram_bank_sched #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       wr_req,
    output logic [1:0]       wr_gnt,
    output logic             wr_bank,
    input  logic [1:0]       wr_done,
    input  logic             rd_req,
    output logic             rd_gnt,
    output logic             rd_bank,
    input  logic             rd_done,
    output logic             sram_sel1,
    output logic             sram_sel2,
    output logic [1:0]       bank_full,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] wr_stall_cnt,
    output logic [CNT_W-1:0] rd_stall_cnt
);

    typedef enum logic [1:0] {
        B_EMPTY = 2'd0,
        B_WRITE = 2'd1,
        B_FULL  = 2'd2,
        B_READ  = 2'd3
    } bank_st_e;

    bank_st_e [1:0] st_q, st_d;
    logic [1:0] owner_q, owner_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       rr_last_q, rr_last_d;
    logic       err_q, err_d;
    logic [1:0] wr_gnt_q, wr_gnt_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_gnt_q, rd_gnt_d;
    logic       rd_bank_q, rd_bank_d;
    logic       sel1_q, sel1_d;
    logic       sel2_q, sel2_d;
    logic [1:0] full_q, full_d;
    logic       busy_q, busy_d;

    logic       busy_now;
    logic       start_ok;
    logic [1:0] owns_wr;
    logic       reading;
    logic [1:0] elig;
    logic       win;

    always_comb begin
        st_d      = st_q;
        owner_d   = owner_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rr_last_d = rr_last_q;
        err_d     = err_q;
        wr_gnt_d  = 2'b00;
        wr_bank_d = 1'b0;
        rd_gnt_d  = 1'b0;
        rd_bank_d = 1'b0;
        owns_wr   = 2'b00;
        reading   = 1'b0;
        win       = 1'b0;

        busy_now = (st_q[0] != B_EMPTY) || (st_q[1] != B_EMPTY);
        start_ok = start && !busy_now;
        if (start && busy_now) begin
            err_d = 1'b1;
        end

        for (int b = 0; b < 2; b++) begin
            if (st_q[b] == B_WRITE) begin
                owns_wr[owner_q[b]] = 1'b1;
            end
            if (st_q[b] == B_READ) begin
                reading = 1'b1;
            end
        end

        // A stray done is flagged but never disturbs a bank it doesn't belong to
        for (int w = 0; w < 2; w++) begin
            if (wr_done[w]) begin
                if (owns_wr[w]) begin
                    for (int b = 0; b < 2; b++) begin
                        if (st_q[b] == B_WRITE && owner_q[b] == 1'(w)) begin
                            st_d[b] = B_FULL;
                        end
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        if (rd_done) begin
            if (reading) begin
                for (int b = 0; b < 2; b++) begin
                    if (st_q[b] == B_READ) begin
                        st_d[b] = B_EMPTY;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end

        elig = wr_req & ~owns_wr;
        if (!start_ok && st_q[wr_ptr_q] == B_EMPTY && elig != 2'b00) begin
            win                = (elig == 2'b11) ? ~rr_last_q : elig[1];
            wr_gnt_d           = win ? 2'b10 : 2'b01;
            wr_bank_d          = wr_ptr_q;
            st_d[wr_ptr_q]     = B_WRITE;
            owner_d[wr_ptr_q]  = win;
            wr_ptr_d           = ~wr_ptr_q;
            rr_last_d          = win;
        end

        if (!start_ok && rd_req && !reading && st_q[rd_ptr_q] == B_FULL) begin
            rd_gnt_d       = 1'b1;
            rd_bank_d      = rd_ptr_q;
            st_d[rd_ptr_q] = B_READ;
            rd_ptr_d       = ~rd_ptr_q;
        end

        if (start_ok) begin
            wr_ptr_d  = 1'b0;
            rd_ptr_d  = 1'b0;
            rr_last_d = 1'b1;
        end

        sel1_d    = (st_d[0] == B_READ);
        sel2_d    = (st_d[1] == B_READ);
        full_d[0] = (st_d[0] == B_FULL);
        full_d[1] = (st_d[1] == B_FULL);
        busy_d    = (st_d[0] != B_EMPTY) || (st_d[1] != B_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q[0]   <= B_EMPTY;
            st_q[1]   <= B_EMPTY;
            owner_q   <= 2'b00;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            rr_last_q <= 1'b1;
            err_q     <= 1'b0;
            wr_gnt_q  <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_gnt_q  <= 1'b0;
            rd_bank_q <= 1'b0;
            sel1_q    <= 1'b0;
            sel2_q    <= 1'b0;
            full_q    <= 2'b00;
            busy_q    <= 1'b0;
        end else begin
            st_q      <= st_d;
            owner_q   <= owner_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rr_last_q <= rr_last_d;
            err_q     <= err_d;
            wr_gnt_q  <= wr_gnt_d;
            wr_bank_q <= wr_bank_d;
            rd_gnt_q  <= rd_gnt_d;
            rd_bank_q <= rd_bank_d;
            sel1_q    <= sel1_d;
            sel2_q    <= sel2_d;
            full_q    <= full_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_gnt    = wr_gnt_q;
    assign wr_bank   = wr_bank_q;
    assign rd_gnt    = rd_gnt_q;
    assign rd_bank   = rd_bank_q;
    assign sram_sel1 = sel1_q;
    assign sram_sel2 = sel2_q;
    assign bank_full = full_q;
    assign busy      = busy_q;
    assign err       = err_q;

`ifdef FSRAM_SCHED_STALL_CNT_EN
    logic [CNT_W-1:0] wr_stall_q, wr_stall_d;
    logic [CNT_W-1:0] rd_stall_q, rd_stall_d;

    always_comb begin
        wr_stall_d = wr_stall_q;
        rd_stall_d = rd_stall_q;
        if (start_ok) begin
            wr_stall_d = '0;
            rd_stall_d = '0;
        end else begin
            if (wr_req != 2'b00 && wr_gnt_d == 2'b00 && wr_stall_q != '1) begin
                wr_stall_d = wr_stall_q + 1'b1;
            end
            if (rd_req && !rd_gnt_d && rd_stall_q != '1) begin
                rd_stall_d = rd_stall_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_stall_q <= '0;
            rd_stall_q <= '0;
        end else begin
            wr_stall_q <= wr_stall_d;
            rd_stall_q <= rd_stall_d;
        end
    end

    assign wr_stall_cnt = wr_stall_q;
    assign rd_stall_cnt = rd_stall_q;
`else
    assign wr_stall_cnt = '0;
    assign rd_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fsram_bank_sched.sv
// tb/tb_fsram_bank_sched.sv - vector-table and scoreboard bench for fsram_bank_sched
module tb_fsram_bank_sched;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       wr_req = 2'b00;
    logic [1:0]       wr_gnt;
    logic             wr_bank;
    logic [1:0]       wr_done = 2'b00;
    logic             rd_req = 1'b0;
    logic             rd_gnt;
    logic             rd_bank;
    logic             rd_done = 1'b0;
    logic             sram_sel1;
    logic             sram_sel2;
    logic [1:0]       bank_full;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] wr_stall_cnt;
    logic [CNT_W-1:0] rd_stall_cnt;

    fsram_bank_sched #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .wr_req       (wr_req),
        .wr_gnt       (wr_gnt),
        .wr_bank      (wr_bank),
        .wr_done      (wr_done),
        .rd_req       (rd_req),
        .rd_gnt       (rd_gnt),
        .rd_bank      (rd_bank),
        .rd_done      (rd_done),
        .sram_sel1    (sram_sel1),
        .sram_sel2    (sram_sel2),
        .bank_full    (bank_full),
        .busy         (busy),
        .err          (err),
        .wr_stall_cnt (wr_stall_cnt),
        .rd_stall_cnt (rd_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       st;
        logic [1:0] wrq;
        logic [1:0] wrd;
        logic       rrq;
        logic       rdd;
        logic [11:0] exp; // {wg[1:0], wb, rg, rb, s1, s2, full[1:0], busy, err, pad}
    } vec_t;

    vec_t        vecs[$];
    logic [11:0] sb[$];
    int          n_run = 0;
    int          n_fail = 0;

    task automatic add(input logic r, input logic s, input logic [1:0] wq, input logic [1:0] wd,
                       input logic rq, input logic rd, input logic [1:0] wg, input logic wb,
                       input logic rg, input logic rb, input logic s1, input logic s2,
                       input logic [1:0] full, input logic bz, input logic er);
        vec_t v;
        v.rst = r; v.st = s; v.wrq = wq; v.wrd = wd; v.rrq = rq; v.rdd = rd;
        v.exp = {wg, wb, rg, rb, s1, s2, full, bz, er, 1'b0};
        vecs.push_back(v);
    endtask

    function automatic logic [11:0] mask_bank(input logic [11:0] w, input logic [11:0] ref_w);
        logic [11:0] m;
        m = w;
        if (ref_w[11:10] == 2'b00) m[9] = 1'b0;
        if (!ref_w[8]) m[7] = 1'b0;
        return m;
    endfunction

    initial begin
        logic [11:0] act;
        logic [11:0] expv;
        //   rst st wrq   wrd   rrq rdd  wg    wb rg rb s1 s2 full  busy err
        add(1, 0, 2'b00, 2'b00, 0, 0,   2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        add(1, 0, 2'b00, 2'b00, 0, 0,   2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        add(0, 0, 2'b01, 2'b00, 0, 0,   2'b01, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        add(0, 0, 2'b00, 2'b00, 0, 0,   2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        add(0, 0, 2'b00, 2'b01, 0, 0,   2'b00, 0, 0, 0, 0, 0, 2'b01, 1, 0);
        add(0, 0, 2'b00, 2'b00, 1, 0,   2'b00, 0, 1, 0, 1, 0, 2'b00, 1, 0);
        add(0, 0, 2'b00, 2'b00, 0, 0,   2'b00, 0, 0, 0, 1, 0, 2'b00, 1, 0);
        add(0, 0, 2'b00, 2'b00, 0, 1,   2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        add(0, 1, 2'b00, 2'b00, 0, 0,   2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        // both writers held: DRAM first, CCM next cycle, then wait
        add(0, 0, 2'b11, 2'b00, 0, 0,   2'b01, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        add(0, 0, 2'b11, 2'b00, 0, 0,   2'b10, 1, 0, 0, 0, 0, 2'b00, 1, 0);
        add(0, 0, 2'b11, 2'b00, 0, 0,   2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        add(0, 0, 2'b00, 2'b01, 0, 0,   2'b00, 0, 0, 0, 0, 0, 2'b01, 1, 0);
        add(0, 0, 2'b00, 2'b10, 0, 0,   2'b00, 0, 0, 0, 0, 0, 2'b11, 1, 0);
        add(0, 0, 2'b00, 2'b00, 1, 0,   2'b00, 0, 1, 0, 1, 0, 2'b10, 1, 0);
        add(0, 0, 2'b00, 2'b00, 1, 0,   2'b00, 0, 0, 0, 1, 0, 2'b10, 1, 0);
        add(0, 0, 2'b00, 2'b00, 0, 1,   2'b00, 0, 0, 0, 0, 0, 2'b10, 1, 0);
        add(0, 0, 2'b01, 2'b00, 1, 0,   2'b01, 0, 1, 1, 0, 1, 2'b00, 1, 0);
        add(0, 0, 2'b00, 2'b00, 0, 0,   2'b00, 0, 0, 0, 0, 1, 2'b00, 1, 0);
        add(0, 0, 2'b00, 2'b00, 0, 1,   2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        // protocol errors: stray CCM done, start while busy
        add(0, 0, 2'b00, 2'b10, 0, 0,   2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 1);
        add(0, 1, 2'b00, 2'b00, 0, 0,   2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 1);
        add(0, 0, 2'b00, 2'b01, 0, 0,   2'b00, 0, 0, 0, 0, 0, 2'b01, 1, 1);
        add(0, 0, 2'b10, 2'b00, 0, 0,   2'b10, 1, 0, 0, 0, 0, 2'b01, 1, 1);
        add(0, 0, 2'b00, 2'b10, 0, 0,   2'b00, 0, 0, 0, 0, 0, 2'b11, 1, 1);
        add(0, 0, 2'b00, 2'b00, 1, 0,   2'b00, 0, 1, 0, 1, 0, 2'b10, 1, 1);
        add(0, 0, 2'b00, 2'b00, 0, 1,   2'b00, 0, 0, 0, 0, 0, 2'b10, 1, 1);
        add(0, 0, 2'b00, 2'b00, 1, 0,   2'b00, 0, 1, 1, 0, 1, 2'b00, 1, 1);
        add(0, 0, 2'b00, 2'b00, 0, 1,   2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 1);
        add(0, 0, 2'b00, 2'b00, 0, 1,   2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 1);
        add(0, 0, 2'b01, 2'b00, 0, 0,   2'b01, 0, 0, 0, 0, 0, 2'b00, 1, 1);
        add(0, 0, 2'b00, 2'b11, 0, 0,   2'b00, 0, 0, 0, 0, 0, 2'b01, 1, 1);
        // mid-operation reset, then fill both banks
        add(1, 0, 2'b00, 2'b00, 0, 0,   2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        add(0, 0, 2'b01, 2'b00, 0, 0,   2'b01, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        add(0, 0, 2'b00, 2'b01, 0, 0,   2'b00, 0, 0, 0, 0, 0, 2'b01, 1, 0);
        add(0, 0, 2'b10, 2'b00, 0, 0,   2'b10, 1, 0, 0, 0, 0, 2'b01, 1, 0);
        add(0, 0, 2'b00, 2'b10, 0, 0,   2'b00, 0, 0, 0, 0, 0, 2'b11, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst     = vecs[i].rst;
            start   = vecs[i].st;
            wr_req  = vecs[i].wrq;
            wr_done = vecs[i].wrd;
            rd_req  = vecs[i].rrq;
            rd_done = vecs[i].rdd;
            sb.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            expv = sb.pop_front();
            act  = {wr_gnt, wr_bank, rd_gnt, rd_bank, sram_sel1, sram_sel2, bank_full, busy, err, 1'b0};
            n_run++;
            if (mask_bank(act, expv) != mask_bank(expv, expv)) begin
                n_fail++;
                $display("FAIL vec%0d {wg,wb,rg,rb,s1,s2,full,busy,err}: got %b want %b",
                         i, act[11:1], expv[11:1]);
            end
        end

        // both banks FULL: a held DRAM request stalls for 10 cycles
        start = 1'b0; wr_done = 2'b00; rd_req = 1'b0; rd_done = 1'b0;
        wr_req = 2'b01;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            n_run++;
            if (wr_gnt != 2'b00) begin
                n_fail++;
                $display("FAIL stall_gnt cycle %0d: got %b want 00", c, wr_gnt);
            end
        end
        wr_req = 2'b00;
        n_run++;
`ifdef FSRAM_SCHED_STALL_CNT_EN
        if (wr_stall_cnt != CNT_W'(10)) begin
`else
        if (wr_stall_cnt != '0) begin
`endif
            n_fail++;
            $display("FAIL wr_stall_cnt: got %0d", wr_stall_cnt);
        end
        n_run++;
        if (rd_stall_cnt != '0) begin
            n_fail++;
            $display("FAIL rd_stall_cnt: got %0d want 0", rd_stall_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
